// File: rtl/benzaiten_mem_pkg.sv
// Shared types for the instruction/data RAM arbiter: FSM states, request
// owner, the latched request payload and the byte-merge helper used by
// partial stores.
package benzaiten_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Request captured at grant time; the RAM side is driven only from this.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
        owner_e          owner;
        logic            err;
    } req_t;

    // Replace the enabled bytes of old_w with the matching bytes of new_w.
    function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_w,
                                                   input logic [XLEN-1:0] new_w,
                                                   input logic [BE_W-1:0] be);
        logic [XLEN-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, with a bounded run of
// data grants so a held fetch request cannot starve.
//  clk, rst      clock, synchronous active-high reset
//  arb_en_i      arbiter is in a cycle where a grant may be issued
//  if_req_i      fetch request
//  d_req_i       data request
//  grant_if_o    fetch wins this cycle (combinational)
//  grant_d_o     data wins this cycle (combinational)
module mem_arb_prio #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_if_o,
    output logic grant_d_o
);

    localparam int unsigned SW      = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam bit   LIMITED    = (MAX_DATA_STREAK != 0);

    logic [SW-1:0] streak_q, streak_d;
    logic          fetch_turn;

    // Grant decision and streak bookkeeping.
    always_comb begin
        grant_if_o = 1'b0;
        grant_d_o  = 1'b0;
        streak_d   = streak_q;
        fetch_turn = LIMITED && (streak_q == STREAK_MAX);

        if (arb_en_i) begin
            if (d_req_i && !(if_req_i && fetch_turn)) begin
                grant_d_o = 1'b1;
            end else if (if_req_i) begin
                grant_if_o = 1'b1;
            end

            // Streak only counts data grants that made a fetch wait.
            if (!if_req_i || grant_if_o) begin
                streak_d = '0;
            end else if (grant_d_o && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between the instruction-fetch port and the
// load/store port. One transaction in flight; partial stores are done as
// read-modify-write; misaligned addresses get an error response without
// touching the RAM.
//  clk, rst                       clock, synchronous active-high reset
//  if_req/if_addr                 fetch request (held until if_ack)
//  if_ack/if_rvalid/if_rdata/if_err  fetch accept pulse and response
//  d_req/d_we/d_be/d_addr/d_wdata data request (held until d_ack)
//  d_ack/d_rvalid/d_rdata/d_err   data accept pulse and response
//  mem_addr/mem_val/mem_rw        RAM address, write data, 1=read 0=write
//  mem_res                        RAM read data
module mem_arbiter
    import benzaiten_mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_val,
    output logic            mem_rw,
    input  logic [XLEN-1:0] mem_res
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    req_t            win;
    logic            arb_en;
    logic            grant_if, grant_d;
    logic [XLEN-1:0] resp_data;

    // Grants are only possible in IDLE and never in a reset cycle.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .arb_en_i  (arb_en),
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .grant_if_o(grant_if),
        .grant_d_o (grant_d)
    );

    // Payload of whichever port wins; fetch is a plain load.
    always_comb begin
        if (grant_d) begin
            win = '{addr: d_addr, we: d_we, be: d_be, wdata: d_wdata,
                    owner: OWN_D, err: (d_addr[1:0] != 2'b00)};
        end else begin
            win = '{addr: if_addr, we: 1'b0, be: '0, wdata: '0,
                    owner: OWN_IF, err: (if_addr[1:0] != 2'b00)};
        end
    end

    // Next-state and request capture.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_d) begin
                    req_d = win;
                    if (win.err) begin
                        state_d = ST_RESP;
                    end else if (!win.we) begin
                        state_d = ST_RD;
                    end else if (win.be == '1) begin
                        state_d = ST_WR;
                    end else if (win.be == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: state_d = ST_RESP;
            ST_RMW_RD:               state_d = ST_RMW_WR;
            ST_RESP:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Port and RAM outputs; everything is forced quiet in a reset cycle so an
    // aborted transaction can neither write nor respond.
    always_comb begin
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if_err    = 1'b0;
        d_err     = 1'b0;
        mem_rw    = 1'b1;
        mem_val   = '0;
        mem_addr  = req_q.addr;
        resp_data = '0;
        if (!rst) begin
            if_ack = grant_if;
            d_ack  = grant_d;
            case (state_q)
                ST_WR: begin
                    mem_rw  = 1'b0;
                    mem_val = req_q.wdata;
                end
                ST_RMW_WR: begin
                    mem_rw  = 1'b0;
                    mem_val = byte_merge(mem_res, req_q.wdata, req_q.be);
                end
                ST_RESP: begin
                    resp_data = (req_q.we || req_q.err) ? '0 : mem_res;
                    if (req_q.owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = resp_data;
                        d_err    = req_q.err;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = resp_data;
                        if_err    = req_q.err;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (MAX_DATA_STREAK=4) with RAM model
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_ack, if_rvalid, if_err, d_ack, d_rvalid, d_err, mem_rw;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_val;
    logic [31:0] mem_res = 32'd0;

    // Strict-data-priority instance, exercised only with misaligned loads
    logic        if_req0, d_req0, d_we0;
    logic [31:0] if_addr0, d_addr0, d_wdata0;
    logic [3:0]  d_be0;
    logic        if_ack0, if_rvalid0, if_err0, d_ack0, d_rvalid0, d_err0, mem_rw0;
    logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_val0;
    logic [31:0] mem_res0;

    mem_arbiter #(.MAX_DATA_STREAK(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_val(mem_val), .mem_rw(mem_rw), .mem_res(mem_res)
    );

    mem_arbiter #(.MAX_DATA_STREAK(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_rvalid(if_rvalid0),
        .if_rdata(if_rdata0), .if_err(if_err0),
        .d_req(d_req0), .d_we(d_we0), .d_be(d_be0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_ack(d_ack0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0), .d_err(d_err0),
        .mem_addr(mem_addr0), .mem_val(mem_val0), .mem_rw(mem_rw0), .mem_res(mem_res0)
    );

    // RAM: read data captured at posedge when reading, write in low phase
    logic [31:0] ram [256];
    int          ram_writes = 0;
    always @(posedge clk) if (mem_rw) mem_res <= ram[mem_addr[9:2]];
    always @(negedge clk) if (!mem_rw) begin
        ram[mem_addr[9:2]] = mem_val;
        ram_writes++;
    end

    // Reference model and scoreboard
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        bit          wr;
        logic [7:0]  idx;
        logic [31:0] wval;
    } exp_t;

    logic [31:0] mdl [256];
    int          exp_writes = 0;
    exp_t        dq[$];
    exp_t        iq[$];
    int          grants[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          d0_grants = 0;
    logic [31:0] last_d_rdata = 32'd0;
    logic [31:0] last_if_rdata = 32'd0;
    logic        last_d_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Expected outcome of an accepted request, from the memory image at accept time
    function automatic exp_t predict(input logic [31:0] addr, input bit we,
                                     input logic [3:0] be, input logic [31:0] wdata, input int at);
        exp_t e;
        e.idx   = addr[9:2];
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.wr    = 1'b0;
        e.wval  = mdl[addr[9:2]];
        if (addr[1:0] != 2'b00) begin
            e.err = 1'b1;
            e.due = at + 1;
        end else if (!we) begin
            e.rdata = mdl[addr[9:2]];
            e.due   = at + 2;
        end else if (be == 4'h0) begin
            e.due = at + 1;
        end else begin
            e.wr = 1'b1;
            for (int b = 0; b < 4; b++)
                if (be[b]) e.wval[8*b +: 8] = wdata[8*b +: 8];
            e.due = (be == 4'hF) ? at + 2 : at + 3;
        end
        return e;
    endfunction

    // Monitor: compares responses against queued expectations
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            dq.delete();
            iq.delete();
            check("rst_mem_rw", 32'(mem_rw), 32'd1);
            check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
            check("rst_rvalids", 32'({if_rvalid, d_rvalid}), 32'd0);
            check("rst_errs", 32'({if_err, d_err}), 32'd0);
        end else begin
            if (d_rvalid) begin
                if (dq.size() == 0) begin
                    fail("d_unexpected_rvalid");
                end else begin
                    e = dq.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", 32'(d_err), 32'(e.err));
                    check("d_latency", 32'(cyc), 32'(e.due));
                    if (e.wr) begin
                        mdl[e.idx] = e.wval;
                        exp_writes++;
                    end
                    last_d_rdata = d_rdata;
                    last_d_err   = d_err;
                end
            end else begin
                check("d_rdata_idle", d_rdata, 32'd0);
            end
            if (if_rvalid) begin
                if (iq.size() == 0) begin
                    fail("if_unexpected_rvalid");
                end else begin
                    e = iq.pop_front();
                    check("if_rdata", if_rdata, e.rdata);
                    check("if_err", 32'(if_err), 32'(e.err));
                    check("if_latency", 32'(cyc), 32'(e.due));
                    last_if_rdata = if_rdata;
                end
            end else begin
                check("if_rdata_idle", if_rdata, 32'd0);
            end
            if (d_ack || if_ack) begin
                check("one_in_flight", 32'(dq.size() + iq.size()), 32'd0);
                check("single_ack", 32'(d_ack && if_ack), 32'd0);
            end
            if (d_ack) begin
                dq.push_back(predict(d_addr, d_we, d_be, d_wdata, cyc));
                grants.push_back(1);
            end
            if (if_ack) begin
                iq.push_back(predict(if_addr, 1'b0, 4'h0, 32'd0, cyc));
                grants.push_back(0);
            end
            // Strict-priority instance: fetch never served, no RAM writes
            check("max0_no_fetch", 32'({if_ack0, if_rvalid0, if_err0, |if_rdata0}), 32'd0);
            check("max0_mem_rw", 32'(mem_rw0), 32'd1);
            if (d_ack0) d0_grants++;
            if (d_rvalid0) begin
                check("max0_err", 32'({d_err0, |d_rdata0, |mem_val0}), 32'h4);
                check("max0_addr", mem_addr0, d_addr0);
            end
        end
    end

    task automatic d_issue(input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 200);
        if (!d_ack) fail("d_ack_timeout");
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
    endtask

    task automatic if_issue(input logic [31:0] addr);
        int n;
        n = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ack && n < 200);
        if (!if_ack) fail("if_ack_timeout");
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = $urandom;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((dq.size() != 0 || iq.size() != 0) && n < 50);
        if (dq.size() != 0 || iq.size() != 0) fail("response_timeout");
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {22'd0, 10'($urandom)};
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int nerr;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'd0;
            mdl[i] = 32'd0;
        end
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        if_req0 = 0; d_req0 = 0; d_we0 = 0; d_be0 = 0; d_wdata0 = 0;
        if_addr0 = 32'h6; d_addr0 = 32'h2; mem_res0 = 32'd0;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_val", mem_val, 32'd0);
        check("reset_mem_rw", 32'(mem_rw), 32'd1);

        // Full store then fetch
        d_issue(1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        wait_quiet();
        if_issue(32'h100);
        wait_quiet();
        check("fetch_after_store", last_if_rdata, 32'hDEADBEEF);

        // Partial store merge
        d_issue(1'b1, 4'hF, 32'h104, 32'h11223344);
        wait_quiet();
        d_issue(1'b1, 4'b0101, 32'h104, 32'hAABBCCDD);
        wait_quiet();
        d_issue(1'b0, 4'h0, 32'h104, 32'd0);
        wait_quiet();
        check("partial_merge", last_d_rdata, 32'h11BB33DD);

        // Store with no byte enables, then misaligned load
        d_issue(1'b1, 4'h0, 32'h100, 32'h12345678);
        wait_quiet();
        check("be0_ram_unchanged", ram[8'h40], 32'hDEADBEEF);
        d_issue(1'b0, 4'hF, 32'h102, 32'd0);
        wait_quiet();
        check("misaligned_err", 32'(last_d_err), 32'd1);
        check("write_count_directed", 32'(ram_writes), 32'(exp_writes));

        // Contention with both requests held
        repeat (3) @(posedge clk);
        #1;
        grants.delete();
        d0_grants = 0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h204;
        if_req0 = 1'b1; d_req0 = 1'b1;
        n = 0;
        while (grants.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0; if_req0 = 1'b0; d_req0 = 1'b0;
        if (grants.size() < 10) begin
            fail("contention_timeout");
        end else begin
            for (int k = 0; k < 10; k++)
                check($sformatf("grant_order_%0d", k), 32'(grants[k]),
                      32'(((k + 1) % 5) != 0));
        end
        check("max0_data_served", 32'(d0_grants >= 5), 32'd1);
        wait_quiet();

        // Reset during the read phase of a partial store
        d_issue(1'b1, 4'hF, 32'h108, 32'h55667788);
        wait_quiet();
        d_issue(1'b1, 4'b0011, 32'h108, 32'h0000AAAA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_ram_unchanged", ram[8'h42], 32'h55667788);
        if_issue(32'h108);
        wait_quiet();
        check("fetch_after_abort", last_if_rdata, 32'h55667788);

        // Randomised traffic on both ports
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    d_issue(1'($urandom), 4'($urandom), rand_addr(), $urandom);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    if_issue(rand_addr());
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join
        wait_quiet();

        check("write_count_final", 32'(ram_writes), 32'(exp_writes));
        nerr = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== mdl[i]) nerr++;
        check("ram_image", 32'(nerr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
